// File: rtl/voice_pwm_mixer.sv
// voice_pwm_mixer: three-voice envelope mixer driving a frame-latched PWM audio bit.
module voice_pwm_mixer #(
  parameter int PWM_BITS = 8,
  parameter int ENV_DIV  = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          voice_in,
  input  logic [2:0]          gate,
  input  logic [11:0]         vol,
  output logic                aud_pwm,
  output logic [PWM_BITS-1:0] level_o,
  output logic                frame_o
);
  localparam int EW = $clog2(ENV_DIV);
  logic [PWM_BITS-1:0] pwm_cnt, level_q, level;
  logic [EW-1:0]       env_cnt;
  logic [2:0][3:0]     env, env_nx, tgt;
  logic [5:0]          mix_sum;
  logic                env_tick, wrap;
  assign env_tick = env_cnt == EW'(ENV_DIV - 1);
  assign wrap     = pwm_cnt == '1;
  assign level    = PWM_BITS'(mix_sum) << (PWM_BITS - 6);
  assign level_o  = level_q;
  // Envelopes move one step toward their target, so a redirect never jumps.
  always_comb begin
    mix_sum = '0;
    tgt     = '0;
    env_nx  = env;
    for (int i = 0; i < 3; i++) begin
      tgt[i]    = gate[i] ? vol[4*i +: 4] : 4'd0;
      env_nx[i] = env[i] < tgt[i] ? env[i] + 4'd1 : env[i] > tgt[i] ? env[i] - 4'd1 : env[i];
      mix_sum   = mix_sum + (voice_in[i] ? 6'(env[i]) : 6'd0);
    end
  end
  // Level latches only at the frame wrap, from pre-tick envelopes, so a frame never glitches.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      pwm_cnt <= '0;
      env_cnt <= '0;
      env     <= '0;
      level_q <= '0;
      aud_pwm <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      env_cnt <= env_tick ? '0 : env_cnt + 1'b1;
      if (env_tick) env <= env_nx;
      if (wrap) level_q <= level;
      aud_pwm <= pwm_cnt < level_q;
      frame_o <= wrap;
    end
  end
endmodule

// File: tb/tb_voice_pwm_mixer.sv
// tb_voice_pwm_mixer: directed vector table plus ramp/redirect/disable/reset sequences.
module tb_voice_pwm_mixer;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, aud_pwm, frame_o;
  logic [2:0]  voice_in = '0, gate = '0;
  logic [11:0] vol = '0;
  logic [7:0]  level_o;
  int          checks = 0, errors = 0;
  voice_pwm_mixer #(.PWM_BITS(8), .ENV_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .voice_in(voice_in), .gate(gate), .vol(vol),
    .aud_pwm(aud_pwm), .level_o(level_o), .frame_o(frame_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  gate;
    logic [11:0] vol;
    logic [2:0]  voice;
    int          level;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_o && n < 600);
    if (!frame_o) chk("frame_timeout", n, -1);
  endtask
  // Starts in a frame_o cycle; counts aud_pwm highs, rising edges and stray frame pulses.
  task automatic measure(input int toggle_at, output int hi, output int rises, output int extra);
    logic prev = 1'b0;
    hi = 0;
    rises = 0;
    extra = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == toggle_at) voice_in = 3'b000;
      if (aud_pwm) hi++;
      if (aud_pwm && !prev) rises++;
      if (k > 0 && frame_o) extra++;
      prev = aud_pwm;
      tick();
    end
    chk("frame_period", int'(frame_o), 1);
    chk("frame_extra", extra, 0);
  endtask
  task automatic wait_env(input string name, input int exp);
    int n = 0;
    logic [3:0] start = dut.env[0];
    while (dut.env[0] == start && n < 10) begin
      tick();
      n++;
    end
    chk(name, int'(dut.env[0]), exp);
  endtask
  initial begin
    int n, hi, rises, extra;
    vecs[0] = '{3'b001, 12'h003, 3'b001, 12};
    vecs[1] = '{3'b111, 12'hFFF, 3'b111, 180};
    vecs[2] = '{3'b111, 12'hFFF, 3'b101, 120};
    vecs[3] = '{3'b000, 12'hFFF, 3'b111, 0};
    vecs[4] = '{3'b010, 12'h050, 3'b010, 20};
    vecs[5] = '{3'b110, 12'h8A0, 3'b111, 72};
    vecs[6] = '{3'b101, 12'h7F2, 3'b011, 8};
    repeat (3) tick();
    chk("rst_aud", int'(aud_pwm), 0);
    chk("rst_level", int'(level_o), 0);
    chk("rst_frame", int'(frame_o), 0);
    chk("rst_env", int'(dut.env[0]), 0);
    gate = 3'b001; vol = 12'h003; voice_in = 3'b001;
    rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      repeat (4) tick();
      chk($sformatf("ramp_env%0d", k), int'(dut.env[0]), k < 3 ? k : 3);
    end
    chk("first_frame_level", int'(level_o), 0);
    wait_frame(n);
    chk("first_frame_start", n, 240);
    chk("ramp_level", int'(level_o), 12);
    measure(-1, hi, rises, extra);
    chk("ramp_hi", hi, 12);
    gate = 3'b000;
    wait_env("release2", 2);
    wait_env("release1", 1);
    wait_env("release0", 0);
    wait_frame(n);
    wait_frame(n);
    chk("release_level", int'(level_o), 0);
    measure(-1, hi, rises, extra);
    chk("release_hi", hi, 0);
    gate = 3'b001; vol = 12'h00F;
    n = 0;
    while (dut.env[0] != 4'd10 && n < 100) begin
      tick();
      n++;
    end
    chk("redirect_reach10", int'(dut.env[0]), 10);
    vol = 12'h004;
    for (int e = 9; e >= 4; e--) wait_env($sformatf("redirect%0d", e), e);
    repeat (12) tick();
    chk("redirect_hold", int'(dut.env[0]), 4);
    foreach (vecs[v]) begin
      gate = vecs[v].gate; vol = vecs[v].vol; voice_in = vecs[v].voice;
      wait_frame(n);
      wait_frame(n);
      chk($sformatf("vec%0d_level", v), int'(level_o), vecs[v].level);
      measure(-1, hi, rises, extra);
      chk($sformatf("vec%0d_hi", v), hi, vecs[v].level);
      chk($sformatf("vec%0d_runs", v), rises, vecs[v].level > 0 ? 1 : 0);
    end
    gate = 3'b111; vol = 12'hFFF; voice_in = 3'b111;
    wait_frame(n);
    wait_frame(n);
    wait_frame(n);
    measure(100, hi, rises, extra);
    chk("toggle_hi", hi, 180);
    chk("toggle_next_level", int'(level_o), 0);
    measure(-1, hi, rises, extra);
    chk("toggle_next_hi", hi, 0);
    voice_in = 3'b111;
    wait_frame(n);
    wait_frame(n);
    chk("disable_pre_level", int'(level_o), 180);
    repeat (50) tick();
    chk("disable_pre_aud", int'(aud_pwm), 1);
    en = 1'b0;
    tick();
    chk("disable_aud", int'(aud_pwm), 0);
    chk("disable_level", int'(level_o), 0);
    chk("disable_frame", int'(frame_o), 0);
    chk("disable_env", int'(dut.env[2]), 0);
    en = 1'b1; gate = 3'b001; vol = 12'h00F; voice_in = 3'b001;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    chk("rstmid_aud", int'(aud_pwm), 0);
    chk("rstmid_level", int'(level_o), 0);
    chk("rstmid_frame", int'(frame_o), 0);
    chk("rstmid_env", int'(dut.env[0]), 0);
    rst = 1'b0;
    wait_frame(n);
    chk("rstmid_frame_gap", n, 256);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/voice_pwm_mixer.md
VOICE_PWM_MIXER -- requirements
Module: voice_pwm_mixer

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, meaning the PWM counter width; the frame is 2^PWM_BITS clk cycles; legal range 6..12.
REQ-002 The block SHALL have parameter ENV_DIV, default 65536, meaning clk cycles per envelope step; legal range >= 2.
REQ-003 The block SHALL have port clk, input, 1, the system clock; the block uses one clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, master play enable, the same switch that enables the sequencers.
REQ-006 The block SHALL have port voice_in, input, 3, square-wave outputs of the three tone generators, on clk.
REQ-007 The block SHALL have port gate, input, 3, per-voice key-on; 1 means the voice envelope targets its volume.
REQ-008 The block SHALL have port vol, input, 12, per-voice target volume; voice i uses bits [4i+3:4i], 0..15.
REQ-009 The block SHALL have port aud_pwm, output, 1, registered PWM audio bit to the board amplifier.
REQ-010 The block SHALL have port level_o, output, PWM_BITS, the current latched frame level, for debug.
REQ-011 The block SHALL have port frame_o, output, 1, a one-cycle pulse in the first cycle of each frame.

Function
REQ-012 pwm_cnt (PWM_BITS) SHALL increment every cycle while en=1 and wrap from 2^PWM_BITS-1 to 0; while en=0 it SHALL be forced to 0.
REQ-013 env_cnt SHALL count 0..ENV_DIV-1 while en=1 and wrap; env_tick is true in the cycle env_cnt==ENV_DIV-1; while en=0 env_cnt SHALL be forced to 0.
REQ-014 Each voice SHALL hold a 4-bit envelope env[i]; target[i] = gate[i] ? vol[i] : 0.
REQ-015 On env_tick, env[i] SHALL step by exactly 1 toward target[i]: +1 if env<target, -1 if env>target, unchanged if equal; it never overshoots and never wraps.
REQ-016 A change of vol or gate mid-ramp SHALL only redirect the next step; no jump of more than 1 per tick is allowed.
REQ-017 mix_sum (6 bits) SHALL equal the sum over i of (voice_in[i] ? env[i] : 0), range 0..45.
REQ-018 frame level SHALL equal mix_sum << (PWM_BITS-6), zero-extended; the maximum is 180 at PWM_BITS=8, so it never reaches 2^PWM_BITS-1.
REQ-019 level_q SHALL load the frame level at the clock edge where pwm_cnt wraps from max to 0, using voice_in and env values of that cycle; it is constant for the whole frame; level_o = level_q.
REQ-020 aud_pwm SHALL be registered as en & (pwm_cnt < level_q); per frame it is high for exactly level_q consecutive cycles, starting one cycle after frame_o.
REQ-021 level_q=0 SHALL keep aud_pwm low for the whole frame; glitches within a frame are not permitted.
REQ-022 frame_o SHALL be registered high for one cycle after each edge where pwm_cnt becomes 0 with en=1.
REQ-023 If en=0, all env[i] and level_q SHALL be cleared to 0 on the next edge, and aud_pwm and frame_o SHALL be 0 from the next edge.
REQ-024 When en rises, the first frame SHALL start with pwm_cnt=0 and level_q=0; the first nonzero level appears in the second frame.
REQ-025 An env_tick and a frame wrap in the same cycle SHALL have level_q sample the pre-tick env values.

Reset
REQ-026 On rst=1 at a clk edge, pwm_cnt, env_cnt, env[0..2], level_q, aud_pwm and frame_o SHALL all become 0, with en ignored.
REQ-027 Reset asserted mid-frame or mid-ramp SHALL abort immediately; after release, behaviour SHALL be identical to a fresh en rise.

Verification
REQ-028 Ramp: PWM_BITS=8, ENV_DIV=4, en=1, gate=001, vol[0]=3, voice_in=001 -> env[0] steps 1,2,3 every 4 cycles then holds; level_o settles at 12; aud_pwm high 12 cycles per 256-cycle frame.
REQ-029 Release: after the ramp, gate=000 -> env[0] steps 2,1,0 on successive ticks; level_o reaches 0 and aud_pwm stays low for the whole following frame.
REQ-030 Full mix: gate=111, vol=FFF, voice_in=111 held -> level_o=180 and aud_pwm high exactly 180 cycles per frame; with voice_in=101 -> level_o=120.
REQ-031 Redirect: env[0]=10 while ramping toward 15, vol[0] changed to 4 -> env steps 9,8,...,4 one per tick, no jump.
REQ-032 Disable/reset: en dropped mid-frame with level 180 -> aud_pwm=0 and level_o=0 the next cycle; a rst pulse mid-ramp -> all outputs 0 the next cycle, and frame_o recurs 256 cycles after release.
REQ-033 Frame timing: frame_o pulses every 256 cycles exactly; a voice_in toggle mid-frame does not change aud_pwm until the next frame.
